// File: rtl/z16_lsu_pkg.sv
// Shared types and constants for the Z16 load/store unit.
package z16_lsu_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned ADDR_BITS_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Request fields still needed after acceptance
    typedef struct packed {
        logic       we;
        logic       is_byte;
        logic       sext;
        logic       lane;
        logic [7:0] wbyte;
    } lsu_req_t;

endpackage

// File: rtl/z16_byte_lane.sv
// Little-endian byte lane extract (with zero/sign extension) and merge.
module z16_byte_lane
    import z16_lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic              lane_i,
    input  logic              sext_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] ext_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = (lane_i == LANE_HI) ? word_i[15:8] : word_i[7:0];
        ext_o    = {{8{sext_i & sel_byte[7]}}, sel_byte};
        merge_o  = (lane_i == LANE_HI) ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};
    end

endmodule

// File: rtl/z16_load_store_unit.sv
// Z16 data-memory initiator: word/byte loads and stores with alignment and
// range checking; byte stores are done as read-modify-write.
module z16_load_store_unit
    import z16_lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_byte,
    input  logic              i_req_sext,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              req_err;
    logic [DATA_W-1:0] lane_ext;
    logic [DATA_W-1:0] lane_merge;

    // Misaligned word access, or any address bit beyond the backed range
    assign req_err = (!i_req_byte & i_req_addr[0])
                   | ((i_req_addr >> ADDR_BITS) != ADDR_W'(0));

    z16_byte_lane u_byte_lane (
        .word_i  (i_mem_rdata),
        .lane_i  (req_q.lane),
        .sext_i  (req_q.sext),
        .byte_i  (req_q.wbyte),
        .ext_o   (lane_ext),
        .merge_o (lane_merge)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    req_d.we      = i_req_we;
                    req_d.is_byte = i_req_byte;
                    req_d.sext    = i_req_sext;
                    req_d.lane    = i_req_addr[0];
                    req_d.wbyte   = i_req_wdata[7:0];
                    if (req_err) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_addr_d = i_req_addr;
                        if (i_req_we && !i_req_byte) begin
                            state_d     = ST_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = i_req_wdata;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (req_q.we) begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = lane_merge;
                end else begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = req_q.is_byte ? lane_ext : i_mem_rdata;
                end
            end
            ST_WR: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_z16_load_store_unit.sv
// Scoreboard bench for z16_load_store_unit with a behavioural word memory.
module tb_z16_load_store_unit;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic        i_req_byte = 1'b0;
    logic        i_req_sext = 1'b0;
    logic [15:0] i_req_addr = '0;
    logic [15:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [15:0] o_mem_addr;
    logic        o_mem_we;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata;

    logic [15:0] mem [0:1023];
    exp_t        exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [15:0] we_addr = '0;
    logic [15:0] we_data = '0;

    z16_load_store_unit dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_byte  (i_req_byte),
        .i_req_sext  (i_req_sext),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr[10:1]];

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mem_we) mem[o_mem_addr[10:1]] <= o_mem_wdata;
    end

    // Response scoreboard and write-strobe monitor
    always @(negedge i_clk) begin
        exp_t e;
        if (o_mem_we) begin
            we_cnt  = we_cnt + 1;
            we_cyc  = cyc;
            we_addr = o_mem_addr;
            we_data = o_mem_wdata;
        end
        if (o_rsp_valid) begin
            rsp_cnt = rsp_cnt + 1;
            rsp_cyc = cyc;
            checks  = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                         o_rsp_rdata, o_rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({o_rsp_rdata, o_rsp_err} !== {e.rdata, e.err}) begin
                    errors = errors + 1;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             o_rsp_rdata, o_rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    // Drive one request and return the acceptance cycle
    task automatic issue(input logic we, input logic is_byte, input logic sext,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         output int acc);
        bit found = 0;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_we = we; i_req_byte = is_byte;
        i_req_sext = sext; i_req_addr = addr; i_req_wdata = wdata;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_req_ready) begin found = 1; acc = cyc; break; end
        end
        checks = checks + 1;
        if (!found) begin
            errors = errors + 1;
            $display("FAIL accept_timeout: got ready=%b, required ready=1 within 20 cycles", o_req_ready);
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n_before, input int acc, input int lat, input string name);
        for (int k = 0; k < 20; k++) begin
            if (rsp_cnt > n_before) break;
            @(negedge i_clk); #1;
        end
        checks = checks + 1;
        if (rsp_cnt <= n_before) begin
            errors = errors + 1;
            $display("FAIL %s_rsp_timeout: got no response, required one", name);
        end else if (rsp_cyc - acc != lat) begin
            errors = errors + 1;
            $display("FAIL %s_rsp_latency: got %0d, required %0d", name, rsp_cyc - acc, lat);
        end
    endtask

    task automatic load(input logic is_byte, input logic sext, input logic [15:0] addr,
                        input logic [15:0] exp_data, input string name);
        int acc;
        int n = rsp_cnt;
        exp_q.push_back('{rdata: exp_data, err: 1'b0});
        issue(1'b0, is_byte, sext, addr, 16'h0000, acc);
        wait_rsp(n, acc, 2, name);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        checks = checks + 1;
        if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_we, o_mem_wdata} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b a=%h we=%b wd=%h, required all 0",
                     o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_we, o_mem_wdata);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checks = checks + 1;
        if (o_req_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL reset_ready: got %b, required 1", o_req_ready);
        end
    endtask

    task automatic test_word_store_load();
        int acc;
        int n = rsp_cnt;
        int w = we_cnt;
        exp_q.push_back('{rdata: 16'h0000, err: 1'b0});
        issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, acc);
        wait_rsp(n, acc, 2, "wstore");
        checks = checks + 1;
        if (we_cnt - w != 1 || we_cyc != acc + 1 || we_addr !== 16'h0010 || we_data !== 16'hBEEF) begin
            errors = errors + 1;
            $display("FAIL wstore_we: got pulses=%0d at +%0d addr=%h data=%h, required 1 at +1 addr=0010 data=BEEF",
                     we_cnt - w, we_cyc - acc, we_addr, we_data);
        end
        load(1'b0, 1'b0, 16'h0010, 16'hBEEF, "wload");
    endtask

    task automatic test_byte_store();
        int acc;
        int n = rsp_cnt;
        int w = we_cnt;
        mem[8] = 16'h1234;
        exp_q.push_back('{rdata: 16'h0000, err: 1'b0});
        issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00AB, acc);
        wait_rsp(n, acc, 3, "bstore");
        checks = checks + 1;
        if (we_cnt - w != 1 || we_cyc != acc + 2 || we_data !== 16'hAB34) begin
            errors = errors + 1;
            $display("FAIL bstore_we: got pulses=%0d at +%0d data=%h, required 1 at +2 data=AB34",
                     we_cnt - w, we_cyc - acc, we_data);
        end
        load(1'b0, 1'b0, 16'h0010, 16'hAB34, "bstore_readback");
        mem[9] = 16'h5678;
        exp_q.push_back('{rdata: 16'h0000, err: 1'b0});
        n = rsp_cnt;
        issue(1'b1, 1'b1, 1'b0, 16'h0012, 16'hFFC3, acc);
        wait_rsp(n, acc, 3, "bstore_lo");
        load(1'b0, 1'b0, 16'h0012, 16'h56C3, "bstore_lo_readback");
    endtask

    task automatic test_byte_load_ext();
        mem[16] = 16'h80F0;
        load(1'b1, 1'b1, 16'h0021, 16'hFF80, "bload_hi_sext");
        load(1'b1, 1'b0, 16'h0021, 16'h0080, "bload_hi_zext");
        load(1'b1, 1'b1, 16'h0020, 16'hFFF0, "bload_lo_sext");
        load(1'b1, 1'b0, 16'h0020, 16'h00F0, "bload_lo_zext");
    endtask

    task automatic test_errors();
        int acc;
        int n = rsp_cnt;
        int w;
        exp_q.push_back('{rdata: 16'h0000, err: 1'b1});
        issue(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, acc);
        wait_rsp(n, acc, 1, "err_misaligned");
        mem[0] = 16'hC0DE;
        w = we_cnt;
        n = rsp_cnt;
        exp_q.push_back('{rdata: 16'h0000, err: 1'b1});
        issue(1'b1, 1'b0, 1'b0, 16'h0800, 16'h1111, acc);
        wait_rsp(n, acc, 1, "err_range");
        repeat (2) @(negedge i_clk);
        checks = checks + 1;
        if (we_cnt != w || mem[0] !== 16'hC0DE) begin
            errors = errors + 1;
            $display("FAIL err_range_nowrite: got pulses=%0d mem0=%h, required 0 pulses mem0=C0DE",
                     we_cnt - w, mem[0]);
        end
        load(1'b1, 1'b0, 16'h0021, 16'h0080, "after_err_byte_odd_ok");
    endtask

    task automatic test_reset_mid();
        int acc;
        int n;
        mem[24] = 16'h7777;
        issue(1'b1, 1'b1, 1'b0, 16'h0031, 16'h0055, acc);
        n = rsp_cnt;
        @(posedge i_clk); #1;
        checks = checks + 1;
        if (o_mem_we !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL rstmid_in_wr: got we=%b, required 1", o_mem_we);
        end
        i_rst = 1'b1;
        #1;
        checks = checks + 1;
        if (o_mem_we !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL rstmid_we_drop: got we=%b, required 0", o_mem_we);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        checks = checks + 1;
        if (o_req_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL rstmid_ready: got %b, required 1", o_req_ready);
        end
        repeat (5) @(negedge i_clk);
        checks = checks + 1;
        if (rsp_cnt != n || mem[24] !== 16'h7777) begin
            errors = errors + 1;
            $display("FAIL rstmid_effect: got rsps=%0d mem=%h, required 0 rsps mem=7777",
                     rsp_cnt - n, mem[24]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [3];
        int acc [3];
        bit found;
        addrs[0] = 16'h0040; addrs[1] = 16'h0042; addrs[2] = 16'h0044;
        mem[32] = 16'hA001; mem[33] = 16'hB002; mem[34] = 16'hC003;
        for (int i = 0; i < 3; i++) exp_q.push_back('{rdata: mem[32 + i], err: 1'b0});
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_byte = 1'b0; i_req_addr = addrs[0];
        for (int i = 0; i < 3; i++) begin
            found = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge i_clk);
                if (o_req_ready) begin found = 1; break; end
            end
            acc[i] = cyc;
            checks = checks + 1;
            if (!found) begin
                errors = errors + 1;
                $display("FAIL b2b_accept_%0d: got no acceptance, required one within 10 cycles", i);
            end
            @(posedge i_clk); #1;
            if (i < 2) i_req_addr = addrs[i + 1];
            else i_req_valid = 1'b0;
            for (int s = 0; s < 2; s++) begin
                @(negedge i_clk);
                checks = checks + 1;
                if (o_req_ready !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL b2b_busy_%0d_%0d: got ready=%b, required 0", i, s, o_req_ready);
                end
            end
        end
        checks = checks + 1;
        if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
            errors = errors + 1;
            $display("FAIL b2b_spacing: got %0d,%0d, required 3,3", acc[1] - acc[0], acc[2] - acc[1]);
        end
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_byte_load_ext();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/z16_load_store_unit.md
Name: z16_load_store_unit

Overview:
- Initiator side of the Z16 data-memory port. It accepts load/store requests from the CPU pipeline and drives the memory's address, write-enable and write-data lines. It captures the memory's combinational read data.
- Adds byte access on top of the word-only memory: byte loads use extraction with zero or sign extension; byte stores use a read-modify-write sequence.
- Checks word alignment and address range. Returns a single-cycle response to the pipeline.

Parameters:
- ADDR_BITS, 11, byte-address bits backed by memory (2^11 bytes = 1024 words); any set address bit at or above ADDR_BITS is an error.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  unit can accept (high only in IDLE)
- i_req_we  in  1  1=store, 0=load
- i_req_byte  in  1  1=byte access, 0=word access
- i_req_sext  in  1  byte load: 1=sign-extend, 0=zero-extend (ignored otherwise)
- i_req_addr  in  16  byte address
- i_req_wdata  in  16  store data (byte store uses [7:0])
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  16  load result; 0 for stores and errors
- o_rsp_err  out  1  misaligned word access or out-of-range address
- o_mem_addr  out  16  byte address to memory (memory uses [10:1])
- o_mem_we  out  1  memory write enable
- o_mem_wdata  out  16  memory write data
- i_mem_rdata  in  16  combinational read data for o_mem_addr

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - All registered outputs are 0: o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_we, o_mem_wdata.
  - o_mem_we drops immediately, so an in-flight WR is aborted. No response is ever issued for a request interrupted by reset.
- Handshake:
  - o_req_ready = (state==IDLE).
  - A request is accepted in the cycle where i_req_valid & o_req_ready is high (cycle A). All request fields are registered at the end of A.
  - The response has no backpressure: o_rsp_valid is high for exactly one cycle.
- Byte order is little-endian: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
- Error at acceptance: err = (!byte & addr[0]) | (addr[15:ADDR_BITS] != 0).
  - Erroring requests go IDLE→RSP with o_rsp_err=1 and o_rsp_rdata=0.
  - o_mem_we is never asserted for them; o_mem_addr does not update.
- State machine (IDLE, RD, WR, RSP), with the cycle in which each state is active:
  - Word load: IDLE→RD (A+1)→RSP (A+2). In RD, o_mem_addr=addr; i_mem_rdata is registered into o_rsp_rdata at the end of RD.
  - Byte load: same path as word load. The selected byte is zero- or sign-extended to 16 bits.
  - Word store: IDLE→WR (A+1)→RSP (A+2). In WR, o_mem_we=1 and o_mem_wdata=wdata; memory is written at the end of A+1.
  - Byte store: IDLE→RD (A+1)→WR (A+2)→RSP (A+3).
    - In RD, the old word is captured.
    - In WR, o_mem_wdata is the old word with the addressed lane replaced by wdata[7:0]; the other lane is unchanged.
  - RSP: o_rsp_valid=1 for one cycle, then IDLE. A new request can be accepted in the cycle after RSP.
- Outputs outside their states:
  - o_mem_we=0 in every state other than WR.
  - o_rsp_valid=0 outside RSP.
  - o_rsp_rdata and o_rsp_err hold their values until the next response.
- Throughput: one request per 3 cycles (4 for byte stores, 2 for errors).
- Changes to request inputs while the unit is not ready have no effect.

Decomposition:
- Package z16_lsu_pkg:
  - state encoding (IDLE, RD, WR, RSP)
  - lane-select constants (LANE_LO=0, LANE_HI=1)
  - default ADDR_BITS
- Sub-module z16_byte_lane: purely combinational.
  - Extract: word, lane and sext in; 16-bit result out.
  - Merge: old word, lane and byte in; new word out.
  - Instantiated once in the FSM module.

Test Plan:
- Word store then load: store addr 0x0010 data 0xBEEF → o_mem_we=1 for exactly one cycle (A+1) with o_mem_addr=0x0010 and o_mem_wdata=0xBEEF; o_rsp_valid at A+2 with err=0. A following load of 0x0010 returns o_rsp_rdata=0xBEEF at A+2.
- Byte store, high lane: memory word 0x0010=0x1234; byte store addr 0x0011 data 0x00AB → RD at A+1, o_mem_wdata=0xAB34 with o_mem_we=1 at A+2, rsp at A+3. A word load then returns 0xAB34.
- Byte load extension: memory word 0x0020=0x80F0. Loads of addr 0x0021 return:
  - sext=1: 0xFF80
  - sext=0: 0x0080
  - addr 0x0020, sext=1: 0xFFF0
- Errors:
  - word load at 0x0003 → rsp at A+1, err=1, rdata=0.
  - word store at 0x0800 → err=1, o_mem_we never high; the memory word at 0x0000 is unchanged.
- Reset mid-operation: assert i_rst during WR of a byte store → o_mem_we falls immediately, no o_rsp_valid, o_req_ready=1 after release; the memory word is unchanged.
- Back-to-back handshake: hold i_req_valid=1 with 3 word loads queued → acceptances spaced 3 cycles apart; o_req_ready=0 in RD/RSP; the 3 responses arrive in order with the correct data.
